// File: rtl/cic_ctrl_pkg.sv
// Shared types and constants for the CIC decimation controller.
package cic_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    WARMUP,
    RUN
  } state_e;

  localparam int MIN_RATE = 2;

endpackage

// File: rtl/cic_phase_cnt.sv
// Modulo-(max_i+1) input-sample phase counter with enable, sync clear and wrap flag.
module cic_phase_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] max_i,
  output logic         wrap_o
);

  logic [W-1:0] phase_q;

  assign wrap_o = en_i && !clr_i && (phase_q == max_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= '0;
    end else if (clr_i) begin
      phase_q <= '0;
    end else if (en_i) begin
      phase_q <= wrap_o ? '0 : phase_q + W'(1);
    end
  end

endmodule

// File: rtl/cic_decim_ctrl.sv
// CIC decimator sequencer: integrator gate/clear, decimated comb strobe, comb settling suppression.
// Defining CIC_CTRL_CNT_EN adds the saturating out_cnt output-sample counter.
module cic_decim_ctrl
  import cic_ctrl_pkg::*;
#(
  parameter int D        = 3,
  parameter int RATE_W   = 8,
  parameter int COMB_LAT = 3
`ifdef CIC_CTRL_CNT_EN
  ,
  parameter int CNT_W    = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [RATE_W-1:0] rate,
  input  logic              in_valid,
  output logic              int_en,
  output logic              int_clr,
  output logic              comb_en,
  output logic              out_valid,
  output logic              busy,
  output logic              cfg_err
`ifdef CIC_CTRL_CNT_EN
  ,
  output logic [CNT_W-1:0]  out_cnt
`endif
);

  localparam int SW = $clog2(D + 2);

  state_e              state_q;
  logic [SW-1:0]       seq_q;
  logic [RATE_W-1:0]   rate_q;
  logic                comb_en_q;
  logic                int_clr_q;
  logic                busy_q;
  logic                cfg_err_q;
  logic [COMB_LAT-1:0] dly_q;
  logic                active;
  logic                rate_ok;
  logic                start_ok;
  logic                wrap;

  assign active   = (state_q == WARMUP) || (state_q == RUN);
  assign rate_ok  = rate >= RATE_W'(MIN_RATE);
  assign start_ok = (state_q == IDLE) && start && !stop && rate_ok;
  assign int_en   = active && in_valid;

  cic_phase_cnt #(.W(RATE_W)) u_phase (
    .clk    (clk),
    .rst    (rst),
    .en_i   (int_en),
    .clr_i  (!active || stop),
    .max_i  (rate_q - RATE_W'(1)),
    .wrap_o (wrap)
  );

  // seq_q counts CLEAR cycles, then reuses itself to count settling strobes in WARMUP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      seq_q     <= '0;
      rate_q    <= '0;
      comb_en_q <= 1'b0;
      int_clr_q <= 1'b0;
      busy_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      dly_q     <= '0;
    end else begin
      cfg_err_q <= 1'b0;
      comb_en_q <= 1'b0;
      dly_q     <= (dly_q << 1) | COMB_LAT'(comb_en_q && (state_q == RUN));
      if (stop && (state_q != IDLE)) begin
        state_q   <= IDLE;
        seq_q     <= '0;
        int_clr_q <= 1'b0;
        busy_q    <= 1'b0;
        dly_q     <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start_ok) begin
              rate_q    <= rate;
              seq_q     <= '0;
              state_q   <= CLEAR;
              int_clr_q <= 1'b1;
              busy_q    <= 1'b1;
            end
            cfg_err_q <= start && !stop && !rate_ok;
          end
          CLEAR: begin
            if (seq_q == SW'(D)) begin
              state_q   <= WARMUP;
              seq_q     <= '0;
              int_clr_q <= 1'b0;
            end else begin
              seq_q <= seq_q + SW'(1);
            end
          end
          WARMUP: begin
            comb_en_q <= wrap;
            if (comb_en_q) begin
              if (seq_q == SW'(D - 1)) begin
                state_q <= RUN;
                seq_q   <= '0;
              end else begin
                seq_q <= seq_q + SW'(1);
              end
            end
          end
          RUN: comb_en_q <= wrap;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign comb_en   = comb_en_q;
  assign int_clr   = int_clr_q;
  assign busy      = busy_q;
  assign cfg_err   = cfg_err_q;
  assign out_valid = dly_q[COMB_LAT-1];

`ifdef CIC_CTRL_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (start_ok) begin
      cnt_q <= '0;
    end else if (out_valid && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign out_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// Randomized and directed bench for cic_decim_ctrl against a cycle-schedule reference model.
module tb_cic_decim_ctrl;
  localparam int D        = 3;
  localparam int RATE_W   = 8;
  localparam int COMB_LAT = 3;
`ifdef CIC_CTRL_CNT_EN
  localparam int CNT_W    = 2;
  localparam int CMAX     = (1 << CNT_W) - 1;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic [RATE_W-1:0] rate = '0;
  logic              in_valid = 1'b0;
  logic              int_en, int_clr, comb_en, out_valid, busy, cfg_err;
`ifdef CIC_CTRL_CNT_EN
  logic [CNT_W-1:0]  out_cnt;
`endif

  cic_decim_ctrl #(
    .D(D), .RATE_W(RATE_W), .COMB_LAT(COMB_LAT)
`ifdef CIC_CTRL_CNT_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .rate(rate), .in_valid(in_valid),
    .int_en(int_en), .int_clr(int_clr), .comb_en(comb_en), .out_valid(out_valid),
    .busy(busy), .cfg_err(cfg_err)
`ifdef CIC_CTRL_CNT_EN
    , .out_cnt(out_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // Model: a run is described by its start cycle s0 and the rate; everything else is scheduled in absolute cycles.
  bit m_act;
  int s0, r_m, k, nstr, pend_comb, cfg_at, e_cnt;
  int ovq[$];
  int clr_log[$], ce_log[$], ov_log[$], cfg_log[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, got, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic model_clear();
    m_act = 1'b0; s0 = 0; r_m = 1; k = 0; nstr = 0;
    pend_comb = -1; cfg_at = -1; e_cnt = 0;
    ovq.delete();
  endtask

  task automatic clear_logs();
    clr_log.delete(); ce_log.delete(); ov_log.delete(); cfg_log.delete();
  endtask

  task automatic step(input bit st, input bit sp, input int rt, input bit iv);
    bit e_busy, e_clr, e_warm, e_ie, e_ce, e_ov, e_cfg;
    @(posedge clk);
    cyc++;
    #1;
    start = st; stop = sp; rate = rt[RATE_W-1:0]; in_valid = iv;
    e_busy = m_act && (cyc > s0);
    e_clr  = e_busy && (cyc <= s0 + D + 1);
    e_warm = e_busy && (cyc >= s0 + D + 2);
    e_ie   = e_warm && iv;
    e_ce   = (pend_comb == cyc);
    while (ovq.size() > 0 && ovq[0] < cyc) void'(ovq.pop_front());
    e_ov   = (ovq.size() > 0) && (ovq[0] == cyc);
    e_cfg  = (cfg_at == cyc);
    @(negedge clk);
    chk("int_en", int_en, e_ie);
    chk("int_clr", int_clr, e_clr);
    chk("comb_en", comb_en, e_ce);
    chk("out_valid", out_valid, e_ov);
    chk("busy", busy, e_busy);
    chk("cfg_err", cfg_err, e_cfg);
`ifdef CIC_CTRL_CNT_EN
    chk("out_cnt", out_cnt, e_cnt);
    if (e_ov && e_cnt < CMAX) e_cnt++;
`endif
    if (int_clr) clr_log.push_back(cyc);
    if (comb_en) ce_log.push_back(cyc);
    if (out_valid) ov_log.push_back(cyc);
    if (cfg_err) cfg_log.push_back(cyc);
    if (e_busy && sp) begin
      m_act = 1'b0;
      pend_comb = -1;
      while (ovq.size() > 0 && ovq[$] > cyc) void'(ovq.pop_back());
    end else if (!m_act) begin
      if (st && !sp) begin
        if (rt >= 2) begin
          m_act = 1'b1; s0 = cyc; r_m = rt; k = 0; nstr = 0; e_cnt = 0;
        end else begin
          cfg_at = cyc + 1;
        end
      end
    end else if (e_warm && iv) begin
      k++;
      if (k % r_m == 0) begin
        pend_comb = cyc + 1;
        nstr++;
        if (nstr > D) ovq.push_back(cyc + 1 + COMB_LAT);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    bit st, sp, iv;
    int rt;
    model_clear();
    clear_logs();
    #1 rst = 1'b1;
    #2;
    chk("rst_int_en", int_en, 0);
    chk("rst_int_clr", int_clr, 0);
    chk("rst_comb_en", comb_en, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cfg_err", cfg_err, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reference run: R=4, continuous input, stop one cycle after a RUN strobe.
    step(1, 0, 4, 1);
    c0 = cyc;
    for (int i = 1; i <= 25; i++) step(i == 15, 0, 9, 1);
    step(0, 1, 9, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
    chk("clr_count", clr_log.size(), 4);
    chk("clr_first", qget(clr_log, 0), c0 + 1);
    chk("clr_last", qget(clr_log, 3), c0 + 4);
    chk("ce_count", ce_log.size(), 5);
    chk("ce_0", qget(ce_log, 0), c0 + 9);
    chk("ce_1", qget(ce_log, 1), c0 + 13);
    chk("ce_2", qget(ce_log, 2), c0 + 17);
    chk("ce_3", qget(ce_log, 3), c0 + 21);
    chk("ce_4", qget(ce_log, 4), c0 + 25);
    chk("ov_count", ov_log.size(), 1);
    chk("ov_0", qget(ov_log, 0), c0 + 24);

    // R=5 with a 2-cycle gap after every 3 samples.
    clear_logs();
    step(1, 0, 5, 0);
    c0 = cyc;
    for (int i = 1; i <= 70; i++) step(0, 0, 0, (i % 5) < 3);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    chk("gap_ce_0", qget(ce_log, 0), c0 + 12);
    chk("gap_ce_1", qget(ce_log, 1), c0 + 21);

    // Rejected starts: rate below minimum, and start together with stop.
    clear_logs();
    step(1, 0, 1, 0);
    c0 = cyc;
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    step(1, 1, 4, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
    chk("cfg_count", cfg_log.size(), 1);
    chk("cfg_at", qget(cfg_log, 0), c0 + 1);
    chk("rej_no_clr", clr_log.size(), 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      st = ($urandom_range(0, 39) == 0);
      sp = ($urandom_range(0, 149) == 0);
      rt = $urandom_range(0, 7);
      iv = ($urandom_range(0, 9) < 7);
      if (st && rt < 2) sp = 1'b0;
      step(st, sp, rt, iv);
    end
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);

    // Asynchronous reset in RUN with an out_valid still in flight.
    step(1, 0, 4, 1);
    c0 = cyc;
    for (int i = 1; i <= 23; i++) step(0, 0, 0, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_int_en", int_en, 0);
    chk("arst_int_clr", int_clr, 0);
    chk("arst_comb_en", comb_en, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    model_clear();
    clear_logs();
    @(posedge clk);
    cyc++;
    #1 rst = 1'b0;
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1);
    chk("arst_no_ov", ov_log.size(), 0);

`ifdef CIC_CTRL_CNT_EN
    // Counter saturation and clear on a new start.
    clear_logs();
    step(1, 0, 2, 1);
    for (int i = 1; i <= 25; i++) step(0, 0, 0, 1);
    chk("cnt_ov_seen", ov_log.size(), 5);
    chk("cnt_sat", out_cnt, 3);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    chk("cnt_hold_idle", out_cnt, 3);
    step(1, 0, 3, 0);
    step(0, 0, 0, 0);
    chk("cnt_clear", out_cnt, 0);
    step(0, 1, 0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
